// File: rtl/rom_page_arbiter_if.sv
// Bundles the requester-side and ROM-controller-side signals of the page arbiter.
// The arbiter takes the slave view; whatever drives the requesters and the ROM takes the master view.
interface rom_page_arbiter_if;
  logic       req0;
  logic       req1;
  logic [5:0] addr0;
  logic [5:0] addr1;
  logic       en0;
  logic       en1;
  logic       ack0;
  logic       ack1;
  logic [7:0] data0;
  logic [7:0] data1;
  logic       rom_req;
  logic [5:0] rom_addr;
  logic       rom_en;
  logic       rom_ack;
  logic [7:0] rom_data;
  logic [1:0] grant;
  logic       timeout_err;

  modport slave (
    input  req0, req1, addr0, addr1, en0, en1, rom_ack, rom_data,
    output ack0, ack1, data0, data1, rom_req, rom_addr, rom_en, grant, timeout_err
  );

  modport master (
    output req0, req1, addr0, addr1, en0, en1, rom_ack, rom_data,
    input  ack0, ack1, data0, data1, rom_req, rom_addr, rom_en, grant, timeout_err
  );
endinterface

// File: rtl/rom_page_arbiter.sv
// Round-robin arbiter sharing one ROM controller between two requesters, one page
// transfer at a time, with an ack timeout and a registered owner that steers the byte stream.
module rom_page_arbiter #(
  parameter int PAGE_BYTES  = 64,
  parameter int ACK_TIMEOUT = 31
) (
  input logic               clk,
  input logic               rst_n,
  rom_page_arbiter_if.slave bus
);
  localparam int CW = $clog2(PAGE_BYTES) + 1;
  localparam int WW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CW-1:0] PAGE_LAST = CW'(PAGE_BYTES - 1);
  localparam logic [CW-1:0] PAGE_FULL = CW'(PAGE_BYTES);
  localparam logic [WW-1:0] WAIT_LAST = WW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, STREAM, RELEASE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_armed;
  logic          r_ptr;
  logic          r_owner;
  logic          r_romReq;
  logic          r_timeoutErr;
  logic [1:0]    r_grant;
  logic [5:0]    r_romAddr;
  logic [CW-1:0] r_byteCnt;
  logic [WW-1:0] r_waitCnt;
  logic          w_winner;
  logic          w_ownEn;
  logic          w_romEn;
  logic          w_timeout;
  logic          w_stream;

  // On a tie the requester not named by the pointer wins; a lone request always wins.
  assign w_stream  = (r_state == STREAM);
  assign w_winner  = (bus.req0 & bus.req1) ? ~r_ptr : bus.req1;
  assign w_ownEn   = (r_grant[0] & bus.en0) | (r_grant[1] & bus.en1);
  assign w_romEn   = w_stream & w_ownEn & (r_byteCnt < PAGE_FULL);
  assign w_timeout = (r_state == WAIT_ACK) & ~bus.rom_ack & (r_waitCnt == WAIT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (r_armed && (bus.req0 || bus.req1)) w_next = ISSUE;
      ISSUE:    w_next = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.rom_ack)    w_next = STREAM;
        else if (w_timeout) w_next = IDLE;
      end
      STREAM:   if (w_romEn && (r_byteCnt == PAGE_LAST)) w_next = RELEASE;
      RELEASE:  w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // r_armed holds off the first grant until one full clock has passed after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_armed      <= 1'b0;
      r_ptr        <= 1'b1;
      r_owner      <= 1'b0;
      r_romReq     <= 1'b0;
      r_timeoutErr <= 1'b0;
      r_grant      <= 2'b00;
      r_romAddr    <= 6'd0;
      r_byteCnt    <= '0;
      r_waitCnt    <= '0;
    end else begin
      r_state      <= w_next;
      r_armed      <= 1'b1;
      r_romReq     <= (r_state == IDLE) && (w_next == ISSUE);
      r_timeoutErr <= w_timeout;
      case (r_state)
        IDLE: begin
          if (w_next == ISSUE) begin
            r_owner   <= w_winner;
            r_grant   <= w_winner ? 2'b10 : 2'b01;
            r_romAddr <= w_winner ? bus.addr1 : bus.addr0;
          end
        end
        ISSUE: begin
          r_byteCnt <= '0;
          r_waitCnt <= '0;
        end
        WAIT_ACK: begin
          if (w_timeout) begin
            r_grant   <= 2'b00;
            r_romAddr <= 6'd0;
            r_ptr     <= r_owner;
          end else if (!bus.rom_ack) begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        STREAM: begin
          if (w_romEn) r_byteCnt <= r_byteCnt + 1'b1;
          if (w_next == RELEASE) r_grant <= 2'b00;
        end
        RELEASE: begin
          r_ptr     <= r_owner;
          r_romAddr <= 6'd0;
        end
        default: ;
      endcase
    end
  end

  // Byte path is steered by the registered owner so requester inputs never reach the other side.
  assign bus.rom_req     = r_romReq;
  assign bus.rom_addr    = r_romAddr;
  assign bus.rom_en      = w_romEn;
  assign bus.grant       = r_grant;
  assign bus.timeout_err = r_timeoutErr;
  assign bus.ack0        = w_stream & r_grant[0] & bus.rom_ack;
  assign bus.ack1        = w_stream & r_grant[1] & bus.rom_ack;
  assign bus.data0       = (w_stream & r_grant[0]) ? bus.rom_data : 8'd0;
  assign bus.data1       = (w_stream & r_grant[1]) ? bus.rom_data : 8'd0;
endmodule

// File: tb/tb_rom_page_arbiter.sv
// Randomized bench for rom_page_arbiter: a transfer-level model predicts the winner,
// the timeout point and the byte routing, and every output is compared through checkOutput.
module tb_rom_page_arbiter;
  localparam int PAGE_BYTES  = 64;
  localparam int ACK_TIMEOUT = 31;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errorCount = 0;
  int   checkCount = 0;
  int   lastServed = 1;
  logic [28:0] allOut;

  rom_page_arbiter_if bus();

  rom_page_arbiter #(
    .PAGE_BYTES (PAGE_BYTES),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign allOut = {bus.grant, bus.rom_req, bus.rom_en, bus.rom_addr, bus.ack0, bus.ack1,
                   bus.data0, bus.data1, bus.timeout_err};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.en0 = 1'b0; bus.en1 = 1'b0;
    bus.rom_ack = 1'b0; bus.rom_data = 8'd0;
  endtask

  // Reset, then release with the given requests already high; nothing may be granted on the first edge.
  task automatic applyReset(input logic r0, input logic r1);
    @(negedge clk);
    rst_n = 1'b0;
    clearInputs();
    bus.rom_data = 8'($urandom);
    #1 checkOutput("reset_outputs", {3'd0, allOut}, 32'd0);
    repeat (2) @(negedge clk);
    lastServed = 1;
    rst_n = 1'b1;
    bus.req0 = r0;
    bus.req1 = r1;
    @(negedge clk);
    #1 checkOutput("first_edge_no_grant", 32'({bus.grant, bus.rom_req}), 32'd0);
  endtask

  // One page transfer; ackDelay >= ACK_TIMEOUT means the ROM never answers,
  // abortAt >= 0 pulls reset once that many bytes have been consumed.
  task automatic applyStimulus(input logic r0, input logic r1, input logic [5:0] a0, input logic [5:0] a1,
                               input int ackDelay, input bit hold, input int abortAt);
    int w;
    int cnt;
    bit acked;
    logic expEn;
    logic [1:0] expGrant;
    logic [5:0] expAddr;
    bus.req0 = r0; bus.req1 = r1; bus.addr0 = a0; bus.addr1 = a1;
    bus.rom_ack = 1'b0; bus.en0 = 1'b0; bus.en1 = 1'b0;
    if (r0 && r1) w = (lastServed == 1) ? 0 : 1;
    else          w = r1 ? 1 : 0;
    expGrant = (w == 1) ? 2'b10 : 2'b01;
    expAddr  = (w == 1) ? a1 : a0;

    @(posedge clk); @(negedge clk); #1;
    checkOutput("issue_grant", 32'(bus.grant), 32'(expGrant));
    checkOutput("issue_rom_req", 32'(bus.rom_req), 32'd1);
    checkOutput("issue_rom_addr", 32'(bus.rom_addr), 32'(expAddr));
    checkOutput("issue_timeout_err", 32'(bus.timeout_err), 32'd0);
    if (!hold) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end

    acked = 1'b0;
    for (int i = 0; i < ACK_TIMEOUT; i++) begin
      @(posedge clk); @(negedge clk);
      if (!hold) begin bus.req0 = 1'($urandom_range(0, 1)); bus.req1 = 1'($urandom_range(0, 1)); end
      bus.rom_ack  = (i == ackDelay);
      bus.rom_data = 8'($urandom);
      bus.en0 = 1'($urandom_range(0, 1));
      bus.en1 = 1'($urandom_range(0, 1));
      #1;
      checkOutput("wait_rom_req", 32'(bus.rom_req), 32'd0);
      checkOutput("wait_rom_en", 32'(bus.rom_en), 32'd0);
      checkOutput("wait_grant", 32'(bus.grant), 32'(expGrant));
      checkOutput("wait_rom_addr", 32'(bus.rom_addr), 32'(expAddr));
      checkOutput("wait_timeout_err", 32'(bus.timeout_err), 32'd0);
      checkOutput("wait_other_side", (w == 1) ? 32'({bus.ack0, bus.data0}) : 32'({bus.ack1, bus.data1}), 32'd0);
      if (i == ackDelay) begin acked = 1'b1; break; end
    end

    if (!acked) begin
      @(posedge clk); @(negedge clk);
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rom_ack = 1'b0;
      #1;
      checkOutput("timeout_pulse", 32'(bus.timeout_err), 32'd1);
      checkOutput("timeout_grant", 32'(bus.grant), 32'd0);
      checkOutput("timeout_rom_addr", 32'(bus.rom_addr), 32'd0);
      lastServed = w;
      @(posedge clk); @(negedge clk); #1;
      checkOutput("timeout_single_pulse", 32'(bus.timeout_err), 32'd0);
      return;
    end

    cnt = 0;
    for (int c = 0; c < 4000 && cnt < PAGE_BYTES; c++) begin
      @(posedge clk); @(negedge clk);
      if (cnt == abortAt) begin
        rst_n = 1'b0;
        clearInputs();
        #1 checkOutput("abort_outputs", {3'd0, allOut}, 32'd0);
        lastServed = 1;
        return;
      end
      if (!hold) begin bus.req0 = 1'($urandom_range(0, 1)); bus.req1 = 1'($urandom_range(0, 1)); end
      bus.en0 = ($urandom_range(0, 3) != 0);
      bus.en1 = ($urandom_range(0, 3) != 0);
      bus.rom_ack  = 1'($urandom_range(0, 1));
      bus.rom_data = 8'($urandom);
      #1;
      expEn = (w == 1) ? bus.en1 : bus.en0;
      checkOutput("stream_rom_en", 32'(bus.rom_en), 32'(expEn));
      checkOutput("stream_grant", 32'(bus.grant), 32'(expGrant));
      checkOutput("stream_rom_addr", 32'(bus.rom_addr), 32'(expAddr));
      if (w == 1) begin
        checkOutput("stream_owner_path", 32'({bus.ack1, bus.data1}), 32'({bus.rom_ack, bus.rom_data}));
        checkOutput("stream_other_side", 32'({bus.ack0, bus.data0}), 32'd0);
      end else begin
        checkOutput("stream_owner_path", 32'({bus.ack0, bus.data0}), 32'({bus.rom_ack, bus.rom_data}));
        checkOutput("stream_other_side", 32'({bus.ack1, bus.data1}), 32'd0);
      end
      if (expEn) cnt++;
    end
    if (cnt < PAGE_BYTES) begin
      checkOutput("stream_bytes_done", 32'(cnt), 32'(PAGE_BYTES));
      return;
    end

    @(posedge clk); @(negedge clk);
    if (!hold) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
    bus.en0 = 1'b1; bus.en1 = 1'b1; bus.rom_ack = 1'b1;
    #1;
    checkOutput("release_rom_side", 32'({bus.rom_req, bus.rom_en, bus.ack0, bus.ack1}), 32'd0);
    checkOutput("release_data", 32'({bus.data0, bus.data1}), 32'd0);
    lastServed = w;
    @(posedge clk); @(negedge clk);
    bus.rom_ack = 1'b0;
    #1;
    checkOutput("idle_grant", 32'(bus.grant), 32'd0);
    checkOutput("idle_rom_addr", 32'(bus.rom_addr), 32'd0);
  endtask

  initial begin
    logic [1:0] pat;
    bus.addr0 = 6'd0;
    bus.addr1 = 6'd0;
    clearInputs();

    applyReset(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 6'h05, 6'h00, 3, 1'b0, -1);
    applyStimulus(1'b0, 1'b1, 6'h1C, 6'h33, 0, 1'b0, -1);
    applyStimulus(1'b1, 1'b0, 6'h3F, 6'h00, 99, 1'b0, -1);
    applyStimulus(1'b1, 1'b1, 6'h0A, 6'h2B, 30, 1'b0, -1);

    applyReset(1'b1, 1'b1);
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, 1'b1, 6'h11, 6'h22, int'($urandom_range(0, 5)), 1'b1, -1);

    applyReset(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 6'h2A, 6'h15, 2, 1'b0, 20);
    applyReset(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 6'h2A, 6'h15, 1, 1'b0, -1);

    for (int t = 0; t < 10; t++) begin
      pat = 2'($urandom_range(1, 3));
      applyStimulus(pat[0], pat[1], 6'($urandom), 6'($urandom), int'($urandom_range(0, 36)), 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errorCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/rom_page_arbiter.md
ROM_PAGE_ARBITER -- requirements
Module: rom_page_arbiter

Interface
REQ-001 Parameter PAGE_BYTES, default 64, bytes streamed per granted page transfer.
REQ-002 Parameter ACK_TIMEOUT, default 31, max cycles waited for rom_ack after issue.
REQ-003 clk  input  1  arbiter clock, same domain as ROM controller.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0 / req1  input  1 each  page request from requester 0 / 1, level.
REQ-006 addr0 / addr1  input  6 each  requested page address from requester 0 / 1.
REQ-007 en0 / en1  input  1 each  byte-consume enable from requester 0 / 1.
REQ-008 ack0 / ack1  output  1 each  data-ready acknowledge routed to requester 0 / 1.
REQ-009 data0 / data1  output  8 each  byte data routed to requester 0 / 1.
REQ-010 rom_req  output  1  data_request to ROM controller.
REQ-011 rom_addr  output  6  page address to ROM controller.
REQ-012 rom_en  output  1  byte enable to ROM controller.
REQ-013 rom_ack  input  1  data_ack from ROM controller.
REQ-014 rom_data  input  8  byte data from ROM controller.
REQ-015 grant  output  2  one-hot current owner, 00 when idle.
REQ-016 timeout_err  output  1  one-cycle pulse on ack timeout.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT_ACK, STREAM, RELEASE; all state, counters and outputs registered.
REQ-018 IDLE: if any reqN high, select winner, latch its address into addr register, set grant one-hot, go ISSUE next cycle.
REQ-019 Arbitration round-robin: pointer names last-served requester; on simultaneous req0&req1 the other one wins; pointer after reset = 1 (requester 0 wins first tie).
REQ-020 Single request wins regardless of pointer.
REQ-021 ISSUE: rom_req=1 for exactly one cycle, rom_addr = latched address; then WAIT_ACK.
REQ-022 rom_addr holds latched address from ISSUE through RELEASE; 0 in IDLE.
REQ-023 WAIT_ACK: on rom_ack=1 go STREAM; wait counter increments each cycle; on counter reaching ACK_TIMEOUT without ack, pulse timeout_err, clear grant, go IDLE, pointer updated to the timed-out requester.
REQ-024 STREAM: rom_en = enN of granted requester; ackN(granted) = rom_ack; dataN(granted) = rom_data; passthrough is combinational from registered grant.
REQ-025 Non-granted requester: ack=0, data=8'd0, its en ignored, at all times.
REQ-026 Byte counter (width ceil(log2(PAGE_BYTES))+1) cleared on ISSUE, increments on each cycle rom_en=1 in STREAM.
REQ-027 When counter reaches PAGE_BYTES, rom_en forced 0 and FSM goes RELEASE.
REQ-028 RELEASE: lasts exactly one cycle, all ROM-side outputs 0, pointer := granted requester, grant := 00; then IDLE.
REQ-029 Requester dropping reqN after grant does not abort; transfer completes only via PAGE_BYTES enables or timeout.
REQ-030 Requests arriving while not IDLE are not queued; they are sampled only in IDLE.
REQ-031 No back-to-back grant: minimum two idle ROM-side cycles (RELEASE, IDLE) between transfers.

Reset
REQ-032 rst_n low, at any time incl. mid-STREAM: state=IDLE, grant=00, rom_req=0, rom_en=0, rom_addr=0, ack0=ack1=0, data0=data1=0, timeout_err=0, counters=0, pointer=1.
REQ-033 First grant no earlier than second rising clk edge after rst_n deasserts.

Verification
REQ-034 req0=1 addr0=6'h05 alone -> grant=01, one-cycle rom_req with rom_addr=05, after rom_ack 64 en0 pulses reach rom_en, data0 mirrors rom_data, RELEASE, grant=00.
REQ-035 req0 and req1 both high from reset, held -> grants 01,10,01,10 in successive transfers.
REQ-036 Granted to 1, en0 toggled during STREAM -> rom_en follows en1 only; ack0=0, data0=0 throughout.
REQ-037 rom_ack never asserted -> timeout_err single pulse 31 cycles after WAIT_ACK entry, grant=00, state IDLE.
REQ-038 rst_n pulsed low at byte 20 of a stream -> all outputs 0 immediately, next req restarts with byte counter 0 and rom_req pulse.
REQ-039 req1 dropped after grant -> transfer still completes all 64 bytes before grant clears.
